pipe_ctrl: RTL

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 37 +++
 rtl/pipe_ctrl_if.sv | 39 +++
 rtl/pipe_ctrl_md_busy_counter.sv | 60 ++++++
 rtl/pipe_ctrl.sv | 44 ++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: MD latencies,
// tuse/tnew distance encoding, MD FSM state encoding, and the per-source
// RAW hazard rule used by the stall logic.
package pipe_ctrl_pkg;

    localparam int unsigned MULT_CYCLES = 5;
    localparam int unsigned DIV_CYCLES  = 10;
    localparam int unsigned CNT_W       = 4;

    // Distance in cycles until a value is needed (tuse) or forwardable (tnew).
    typedef logic [1:0] tdist_t;
    localparam tdist_t T_NOW    = 2'd0;
    localparam tdist_t T_ONE    = 2'd1;
    localparam tdist_t T_TWO    = 2'd2;
    localparam tdist_t T_UNUSED = 2'd3;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    function automatic logic [CNT_W-1:0] md_cycles(input logic is_div);
        return is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    endfunction

    // A source stalls against one producer when it reads the producer's
    // destination and the result arrives later than it is needed. $0 is
    // hardwired, so it can never be a real dependency. An unused source
    // (tuse=3) can never stall since tnew is at most 3.
    function automatic logic src_hazard(input logic [4:0] src,
                                        input tdist_t     tuse,
                                        input logic [4:0] waddr,
                                        input tdist_t     tnew);
        return (src != 5'd0) && (src == waddr) && (tnew > tuse);
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard-controller signal bundle between the pipeline datapath and pipe_ctrl.
// master: datapath side (drives D/E/M stage info, receives enables).
// slave:  pipe_ctrl side (reads stage info, drives enables, flush, md_busy, stall).
interface pipe_ctrl_if;
    import pipe_ctrl_pkg::*;

    logic [4:0] D_rs;
    logic [4:0] D_rt;
    tdist_t     D_tuseRs;
    tdist_t     D_tuseRt;
    logic       D_isMd;
    logic [4:0] E_wAddr;
    logic [4:0] M_wAddr;
    tdist_t     E_tnew;
    tdist_t     M_tnew;
    logic       E_mdStart;
    logic       E_mdDiv;

    logic       pc_en;
    logic       fd_en;
    logic       de_flush;
    logic       em_en;
    logic       mw_en;
    logic       md_busy;
    logic       stall;

    modport master (
        output D_rs, D_rt, D_tuseRs, D_tuseRt, D_isMd,
               E_wAddr, M_wAddr, E_tnew, M_tnew, E_mdStart, E_mdDiv,
        input  pc_en, fd_en, de_flush, em_en, mw_en, md_busy, stall
    );

    modport slave (
        input  D_rs, D_rt, D_tuseRs, D_tuseRt, D_isMd,
               E_wAddr, M_wAddr, E_tnew, M_tnew, E_mdStart, E_mdDiv,
        output pc_en, fd_en, de_flush, em_en, mw_en, md_busy, stall
    );

endinterface

// File: rtl/pipe_ctrl_md_busy_counter.sv
// Tracks the multiply/divide unit occupancy: IDLE/BUSY FSM with a down-counter.
// Ports: clk, reset (sync, active-high), md_start/md_div from E, md_busy (registered).
// A start at cycle t raises md_busy for cycles t+1..t+N; starts while BUSY are ignored.
module md_busy_counter
    import pipe_ctrl_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic md_start,
    input  logic md_div,
    output logic md_busy
);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             md_busy_q, md_busy_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            MD_IDLE: begin
                if (md_start) begin
                    state_d = MD_BUSY;
                    cnt_d   = md_cycles(md_div);
                end
            end
            MD_BUSY: begin
                // A start arriving here (even on the final cycle) is dropped;
                // the issuing stage is held off by md_stall until IDLE.
                if (cnt_q == CNT_W'(1)) begin
                    state_d = MD_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = MD_IDLE;
                cnt_d   = '0;
            end
        endcase
        md_busy_d = (state_d == MD_BUSY);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= MD_IDLE;
            cnt_q     <= '0;
            md_busy_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            md_busy_q <= md_busy_d;
        end
    end

    assign md_busy = md_busy_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: RAW data stalls, MD-unit structural stalls, enables.
// Ports: clk, reset (sync, active-high), hz (pipe_ctrl_if.slave) carrying D/E/M info out to enables.
// Stall is combinational (same cycle); freezes PC and F/D, bubbles D/E; E/M and M/W never stall.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    pipe_ctrl_if.slave  hz
);

    logic md_busy;
    logic data_stall;
    logic md_stall;
    logic stall_int;

    md_busy_counter u_md (
        .clk      (clk),
        .reset    (reset),
        .md_start (hz.E_mdStart),
        .md_div   (hz.E_mdDiv),
        .md_busy  (md_busy)
    );

    always_comb begin
        data_stall = src_hazard(hz.D_rs, hz.D_tuseRs, hz.E_wAddr, hz.E_tnew)
                   | src_hazard(hz.D_rs, hz.D_tuseRs, hz.M_wAddr, hz.M_tnew)
                   | src_hazard(hz.D_rt, hz.D_tuseRt, hz.E_wAddr, hz.E_tnew)
                   | src_hazard(hz.D_rt, hz.D_tuseRt, hz.M_wAddr, hz.M_tnew);
        // E_mdStart covers the cycle before md_busy rises.
        md_stall   = hz.D_isMd & (hz.E_mdStart | md_busy);
        // Reset forces free-running enables so pipeline registers take their reset values.
        stall_int  = (data_stall | md_stall) & ~reset;
    end

    assign hz.stall    = stall_int;
    assign hz.pc_en    = ~stall_int;
    assign hz.fd_en    = ~stall_int;
    assign hz.de_flush = stall_int;
    assign hz.em_en    = 1'b1;
    assign hz.mw_en    = 1'b1;
    assign hz.md_busy  = md_busy;

endmodule
